// File: rtl/klingon_decoder.sv
// klingon_decoder: registered 4-bit to 7-segment glyph decoder.
// One instance drives one display digit. The lookup is purely combinational
// and feeds a single output register, so the display pins only change on a
// clock edge. ACTIVE_LOW inverts every segment bit ahead of the register
// so that a common-anode display can be driven directly.
// Segment order is O[6:0] = {g,f,e,d,c,b,a}.
module klingon_decoder #(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] I,
  output logic [6:0] O
);

  // Polarity mask applied at the register input. In the active-low build
  // the blank pattern becomes all-ones, which leaves every segment unlit.
  localparam logic [6:0] POL_MASK = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [6:0] BLANK    = POL_MASK;

  // Glyph table in active-high form ({g..a}, lit = 1). Every code is
  // distinct and nonzero, so a blank display can only mean
  // "reset/uninitialised".
  function automatic logic [6:0] glyph_lookup(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'd0:    seg = 7'h01;
      4'd1:    seg = 7'h08;
      4'd2:    seg = 7'h40;
      4'd3:    seg = 7'h49;
      4'd4:    seg = 7'h30;
      4'd5:    seg = 7'h06;
      4'd6:    seg = 7'h36;
      4'd7:    seg = 7'h37;
      4'd8:    seg = 7'h3E;
      4'd9:    seg = 7'h7F;
      4'd10:   seg = 7'h76;
      4'd11:   seg = 7'h5C;
      4'd12:   seg = 7'h63;
      4'd13:   seg = 7'h1C;
      4'd14:   seg = 7'h23;
      4'd15:   seg = 7'h2D;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

  logic [6:0] glyph_s;
  logic [6:0] seg_next_s;
  logic [6:0] o_r;

  // Combinational lookup and polarity adjustment for the register input.
  always_comb begin
    glyph_s    = 7'h00;
    seg_next_s = BLANK;
    glyph_s    = glyph_lookup(I);
    if (rst) begin
      seg_next_s = BLANK;
    end else begin
      seg_next_s = glyph_s ^ POL_MASK;
    end
  end

  // Output register: one-cycle latency, with reset taking priority over I.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_r <= BLANK;
    end else begin
      o_r <= seg_next_s;
    end
  end

  assign O = o_r;

endmodule

// File: tb/tb_klingon_decoder.sv
// Directed self-checking bench for klingon_decoder. Both polarity builds
// share the same clock, reset and input, and every step checks both.
module tb_klingon_decoder;

  logic       clk;
  logic       rst;
  logic [3:0] I;
  logic [6:0] o_hi;
  logic [6:0] o_lo;

  int checks_total;
  int checks_failed;

  // Expected active-high glyphs, entered by hand from the glyph table.
  logic [6:0] glyph_tab [16];

  klingon_decoder #(.ACTIVE_LOW(1'b0)) dut_hi (
    .clk (clk),
    .rst (rst),
    .I   (I),
    .O   (o_hi)
  );

  klingon_decoder #(.ACTIVE_LOW(1'b1)) dut_lo (
    .clk (clk),
    .rst (rst),
    .I   (I),
    .O   (o_lo)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to 1 ns past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [6:0] observed,
                       input logic [6:0] expected);
    checks_total = checks_total + 1;
    assert (observed === expected) else begin
      checks_failed = checks_failed + 1;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Check both builds against one active-high expectation.
  task automatic check_both(input string tag, input logic [6:0] exp_hi);
    check({tag, "_hi"}, o_hi, exp_hi);
    check({tag, "_lo"}, o_lo, exp_hi ^ 7'h7F);
  endtask

  initial begin
    checks_total  = 0;
    checks_failed = 0;
    glyph_tab = '{7'h01, 7'h08, 7'h40, 7'h49, 7'h30, 7'h06, 7'h36, 7'h37,
                  7'h3E, 7'h7F, 7'h76, 7'h5C, 7'h63, 7'h1C, 7'h23, 7'h2D};

    // Reset held for two edges with I=9: blank both times.
    rst = 1'b1;
    I   = 4'd9;
    tick();
    check("reset_e1_hi", o_hi, 7'h00);
    check("reset_e1_lo", o_lo, 7'h7F);
    tick();
    check("reset_e2_hi", o_hi, 7'h00);
    check("reset_e2_lo", o_lo, 7'h7F);

    // Release: first edge loads glyph 9 with no extra wait cycle.
    rst = 1'b0;
    tick();
    check("release_hi", o_hi, 7'h7F);
    check("release_lo", o_lo, 7'h00);

    // Full sweep 0..15, one value per cycle.
    for (int k = 0; k < 16; k++) begin
      I = 4'(k);
      tick();
      check_both($sformatf("sweep_%0d", k), glyph_tab[k]);
    end
    // Explicit active-low spot values.
    I = 4'd0;
    tick();
    check("al_code0", o_lo, 7'h7E);
    I = 4'd15;
    tick();
    check("al_code15", o_lo, 7'h52);

    // Hold I=3 for three cycles, then change to 12.
    I = 4'd3;
    tick();
    check_both("hold_c1", 7'h49);
    tick();
    check_both("hold_c2", 7'h49);
    tick();
    check_both("hold_c3", 7'h49);
    I = 4'd12;
    #3;
    check_both("hold_pre_edge", 7'h49);
    tick();
    check_both("hold_change", 7'h63);

    // Mid-stream reset pulse at I=7.
    I = 4'd5;
    tick();
    check_both("mid_5", 7'h06);
    I = 4'd6;
    tick();
    check_both("mid_6", 7'h36);
    I   = 4'd7;
    rst = 1'b1;
    tick();
    check_both("mid_rst", 7'h00);
    rst = 1'b0;
    I   = 4'd8;
    tick();
    check_both("mid_resume_8", 7'h3E);
    I = 4'd9;
    tick();
    check_both("mid_resume_9", 7'h7F);

    // Glitch: I toggles 5->10->5 between edges; O follows the edge value only.
    I = 4'd5;
    tick();
    check_both("glitch_base", 7'h06);
    I = 4'd10;
    #2;
    I = 4'd5;
    #2;
    check_both("glitch_mid", 7'h06);
    tick();
    check_both("glitch_edge5", 7'h06);
    I = 4'd5;
    #2;
    I = 4'd10;
    #2;
    check_both("glitch_mid2", 7'h06);
    tick();
    check_both("glitch_edge10", 7'h76);

    $display("%0d/%0d checks passed", checks_total - checks_failed, checks_total);
    $finish;
  end

endmodule

// File: doc/klingon_decoder.md
Name: klingon_decoder

Overview:
- Registered glyph decoder: maps a 4-bit value (0-15) to a fixed 7-segment pattern drawing the team's Klingon-style digit glyphs.
- Sits between the numeric datapath and the seven-segment display driver pins; one instance per display digit.
- Output is registered (one-cycle latency) so the display pins are glitch-free.

Parameters:
- ACTIVE_LOW, 0, when 1 every output bit is inverted at the register input (common-anode display); when 0, segment lit = 1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- I  input  4  value to display, unsigned 0-15.
- O  output  7  segment drive, bit order O[6:0] = {g,f,e,d,c,b,a} (a = top, b = top-right, c = bottom-right, d = bottom, e = bottom-left, f = top-left, g = middle).

Behaviour:
- Single output register O; no other state. Purely combinational lookup of I feeds the register.
- Reset: on a rising clk edge with rst=1, O <= blank (7'h00 if ACTIVE_LOW=0, 7'h7F if ACTIVE_LOW=1). rst dominates I.
- Normal: on each rising edge with rst=0, O <= GLYPH[I] (XOR 7'h7F when ACTIVE_LOW=1).
- Latency: exactly 1 clock from I to O; I sampled at the edge, no handshake, a new value is accepted every cycle.
- GLYPH table (ACTIVE_LOW=0, hex of {g..a}):
  0->01, 1->08, 2->40, 3->49, 4->30, 5->06, 6->36, 7->37,
  8->3E, 9->7F, 10->76, 11->5C, 12->63, 13->1C, 14->23, 15->2D.
- All 16 codes are distinct and none equals the blank pattern, so blank means only "reset/uninitialised".
- Full 4-bit range is legal; no out-of-range input exists. X/Z on I is not defended against.
- Reset deasserted mid-stream: the first edge with rst=0 loads GLYPH[I] for the I present at that edge; no extra wait cycle.
- Reset asserted mid-stream: O is blank at the very next edge regardless of I.
- I changing between edges has no effect on O until the next edge.

Test Plan:
- Reset: rst=1 for 2 cycles with I=9 -> O=7'h00 after first edge; release rst -> O=7'h7F one edge later.
- Sweep: rst=0, I=0..15 one value per cycle -> O one cycle later = 01,08,40,49,30,06,36,37,3E,7F,76,5C,63,1C,23,2D in order.
- Latency/hold: I=3 held 3 cycles, then I=12 -> O=49 for 3 cycles, then 63 exactly one edge after the change.
- Mid-stream reset: during the sweep, assert rst for 1 cycle at I=7 -> O=00 for that cycle, resumes with the next value's glyph one edge after rst drops.
- ACTIVE_LOW=1 build: reset -> O=7F; I=0 -> O=7E; I=9 -> O=00; I=15 -> O=52.
- Glitch check: toggle I between edges (5->10->5 within one cycle) -> O changes only at clock edges and reflects the value present at the edge.
